// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal TX FIFO, 5..DATA_W bit characters, four parity modes,
// CTS flow control and break generation. Bit period is cfg_div_i+1 clock cycles.
module uart_tx_fifo #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     tx_empty_o,
  input  logic                     cfg_en_i,
  input  logic [15:0]              cfg_div_i,
  input  logic [2:0]               cfg_bits_i,
  input  logic                     cfg_parity_en_i,
  input  logic [1:0]               cfg_parity_mode_i,
  input  logic                     cfg_stop_bits_i,
  input  logic                     cfg_cts_en_i,
  input  logic                     cts_ni,
  input  logic                     break_i,
  input  logic                     fifo_clr_i,
  input  logic [DATA_W-1:0]        tx_data_i,
  input  logic                     tx_valid_i,
  output logic                     tx_ready_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 16;
  localparam int unsigned NW = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_c, empty_c, push_c, pop_c;
  logic [DATA_W-1:0] head_c;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, div_q, div_d;
  logic [NW-1:0]     bit_q, bit_d, nbits_q, nbits_d, nbits_c;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic              par_x, par_calc_c, bit_done_c, cts_ok_c, tx_d;

  assign full_c       = (level_q == LW'(DEPTH));
  assign empty_c      = (level_q == '0);
  assign tx_ready_o   = cfg_en_i & ~full_c;
  assign push_c       = tx_valid_i & tx_ready_o & ~fifo_clr_i;
  assign head_c       = mem_q[rd_ptr_q];
  assign fifo_level_o = level_q;
  assign cts_ok_c     = ~cfg_cts_en_i | ~cts_ni;
  assign bit_done_c   = (cnt_q == div_q);

  // Character width clamped to the widest supported character.
  assign nbits_c = ((NW'(cfg_bits_i) + NW'(5)) > NW'(DATA_W)) ? NW'(DATA_W)
                                                              : NW'(cfg_bits_i) + NW'(5);

  // Parity over only the bits that will actually be shifted out.
  always_comb begin
    par_x = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (NW'(i) < nbits_c) par_x = par_x ^ head_c[i];
    end
    case (cfg_parity_mode_i)
      2'b00:   par_calc_c = par_x;
      2'b01:   par_calc_c = ~par_x;
      2'b10:   par_calc_c = 1'b0;
      default: par_calc_c = 1'b1;
    endcase
  end

  // FIFO pointer/level next state; a flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (fifo_clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_c && !pop_c)      level_d = level_q + LW'(1);
      else if (!push_c && pop_c) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= tx_data_i;
  end

  // Frame sequencer next state; frame config is captured at the pop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    div_d     = div_q;
    pop_c     = 1'b0;
    if (!cfg_en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (break_i) begin
            state_d = BREAK;
            div_d   = cfg_div_i;
            stop2_d = 1'b0;
          end else if (!empty_c && cts_ok_c) begin
            pop_c     = 1'b1;
            state_d   = START;
            shreg_d   = head_c;
            nbits_d   = nbits_c;
            par_en_d  = cfg_parity_en_i;
            par_bit_d = par_calc_c;
            stop2_d   = cfg_stop_bits_i;
            div_d     = cfg_div_i;
          end
        end
        START: if (bit_done_c) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
        DATA: if (bit_done_c) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == nbits_q - NW'(1)) state_d = par_en_q ? PARITY : STOP1;
          else                           bit_d   = bit_q + NW'(1);
        end
        PARITY: if (bit_done_c) begin
          state_d = STOP1;
          cnt_d   = '0;
        end
        STOP1: if (bit_done_c) begin
          state_d = stop2_q ? STOP2 : IDLE;
          cnt_d   = '0;
        end
        STOP2: if (bit_done_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        BREAK: begin
          cnt_d = '0;
          if (!break_i) state_d = STOP1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Line level for the state being entered, so tx_o is a plain flop.
  always_comb begin
    case (state_d)
      START, BREAK: tx_d = 1'b0;
      DATA:         tx_d = shreg_d[0];
      PARITY:       tx_d = par_bit_d;
      default:      tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      nbits_q    <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      tx_empty_o <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      nbits_q    <= nbits_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_o       <= tx_d;
      busy_o     <= (state_d != IDLE);
      tx_empty_o <= (level_d == '0) && (state_d == IDLE);
    end
  end

endmodule
